// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered N-input priority arbiter with fixed or round-robin winner selection and a valid/ready output
module prio_encoder_rr #(
   parameter int N    = 8,
   parameter int IDXW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            rr_mode,
   input  logic [N-1:0]    req,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx
);
   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
   logic            valid_q, valid_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IDXW-1:0] idx_q, idx_d, ptr_q, ptr_d;
   logic [IDXW-1:0] fx_w, rr_w, rr_cur, w;
   logic            rr_found, accept, load;
   // fixed priority: ascending scan so the highest set index is the last to overwrite
   always_comb begin
      fx_w = '0;
      for (int i = 0; i < N; i++)
         if (req[i]) fx_w = IDXW'(i);
   end
   // round-robin: scan downward from ptr with wrap, first set bit wins
   always_comb begin
      rr_w     = '0;
      rr_found = 1'b0;
      rr_cur   = ptr_q;
      for (int k = 0; k < N; k++) begin
         if (!rr_found && req[rr_cur]) begin
            rr_w     = rr_cur;
            rr_found = 1'b1;
         end
         rr_cur = (rr_cur == '0) ? LAST : rr_cur - IDXW'(1);
      end
   end
   // next state: a stalled grant holds; otherwise load a new winner or go idle
   always_comb begin
      accept  = !valid_q || out_ready;
      load    = accept && en && (req != '0);
      w       = rr_mode ? rr_w : fx_w;
      valid_d = accept ? load : valid_q;
      gnt_d   = accept ? (load ? (N'(1) << w) : '0) : gnt_q;
      idx_d   = accept ? (load ? w : '0) : idx_q;
      ptr_d   = (load && rr_mode) ? ((w == '0) ? LAST : w - IDXW'(1)) : ptr_q;
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= LAST;
      end else begin
         valid_q <= valid_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end
   assign out_valid = valid_q;
   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: directed checks of an N=4 and an N=8 arbiter instance
module tb_prio_encoder_rr;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   logic       rst4, en4, rr4, rdy4, v4;
   logic [3:0] req4, g4;
   logic [1:0] i4;
   logic       rst8, en8, rr8, rdy8, v8;
   logic [7:0] req8, g8;
   logic [2:0] i8;
   prio_encoder_rr #(.N(4), .IDXW(2)) d4 (
      .clk(clk), .rst_n(rst4), .en(en4), .rr_mode(rr4), .req(req4),
      .out_ready(rdy4), .out_valid(v4), .gnt(g4), .gnt_idx(i4));
   prio_encoder_rr #(.N(8), .IDXW(3)) d8 (
      .clk(clk), .rst_n(rst8), .en(en8), .rr_mode(rr8), .req(req8),
      .out_ready(rdy8), .out_valid(v8), .gnt(g8), .gnt_idx(i8));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst4 = 1'b0; en4 = 1'b1; rr4 = 1'b0; rdy4 = 1'b1; req4 = 4'hF;
      rst8 = 1'b0; en8 = 1'b1; rr8 = 1'b0; rdy8 = 1'b1; req8 = 8'hFF;
      tick();
      tick();
      checks++;
      if ({v4, g4, i4} !== 7'b0) begin
         errors++;
         $display("FAIL reset4: got v=%0b g=%b i=%0d want v=0 g=0000 i=0", v4, g4, i4);
      end
      checks++;
      if ({v8, g8, i8} !== 12'b0) begin
         errors++;
         $display("FAIL reset8: got v=%0b g=%b i=%0d want v=0 g=00000000 i=0", v8, g8, i8);
      end
      rst4 = 1'b1; rst8 = 1'b1; req4 = 4'h0; req8 = 8'h0;
   endtask

   task automatic test_fixed();
      logic [3:0] rv [7] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'hA, 4'h6};
      logic       ev [7] = '{1, 1, 1, 1, 0, 1, 1};
      logic [3:0] eg [7] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h8, 4'h4};
      logic [1:0] ei [7] = '{3, 2, 1, 0, 0, 3, 2};
      rr4 = 1'b0; en4 = 1'b1; rdy4 = 1'b1;
      for (int n = 0; n < 7; n++) begin
         req4 = rv[n];
         tick();
         checks++;
         if ({v4, g4, i4} !== {ev[n], eg[n], ei[n]}) begin
            errors++;
            $display("FAIL fixed[%0d] req=%b: got v=%0b g=%b i=%0d want v=%0b g=%b i=%0d",
                     n, rv[n], v4, g4, i4, ev[n], eg[n], ei[n]);
         end
      end
   endtask

   task automatic test_enable();
      en4 = 1'b0; req4 = 4'b1000; rdy4 = 1'b1; rr4 = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++;
         if (v4 !== 1'b0 || g4 !== 4'b0) begin
            errors++;
            $display("FAIL en_off[%0d]: got v=%0b g=%b want v=0 g=0000", n, v4, g4);
         end
      end
      en4 = 1'b1;
      tick();
      checks++;
      if ({v4, g4, i4} !== {1'b1, 4'b1000, 2'd3}) begin
         errors++;
         $display("FAIL en_on: got v=%0b g=%b i=%0d want v=1 g=1000 i=3", v4, g4, i4);
      end
   endtask

   task automatic test_rr();
      logic [1:0] seq1 [6] = '{3, 2, 1, 0, 3, 2};
      logic [1:0] seq2 [4] = '{2, 0, 2, 0};
      rst4 = 1'b0;
      tick();
      rst4 = 1'b1; rr4 = 1'b1; en4 = 1'b1; rdy4 = 1'b1; req4 = 4'b1111;
      for (int n = 0; n < 6; n++) begin
         tick();
         checks++;
         if ({v4, g4, i4} !== {1'b1, 4'(1 << seq1[n]), seq1[n]}) begin
            errors++;
            $display("FAIL rr_all[%0d]: got v=%0b g=%b i=%0d want v=1 i=%0d", n, v4, g4, i4, seq1[n]);
         end
      end
      req4 = 4'b1000;
      for (int n = 0; n < 2; n++) begin
         tick();
         checks++;
         if ({v4, i4} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL rr_single[%0d]: got v=%0b i=%0d want v=1 i=3", n, v4, i4);
         end
      end
      req4 = 4'b0101;
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++;
         if ({v4, g4, i4} !== {1'b1, 4'(1 << seq2[n]), seq2[n]}) begin
            errors++;
            $display("FAIL rr_0101[%0d]: got v=%0b g=%b i=%0d want v=1 i=%0d", n, v4, g4, i4, seq2[n]);
         end
      end
   endtask

   task automatic test_stall();
      rr4 = 1'b0; en4 = 1'b1; rdy4 = 1'b1; req4 = 4'b1000;
      tick();
      rdy4 = 1'b0; req4 = 4'b0001; en4 = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++;
         if ({v4, g4, i4} !== {1'b1, 4'b1000, 2'd3}) begin
            errors++;
            $display("FAIL stall[%0d]: got v=%0b g=%b i=%0d want v=1 g=1000 i=3", n, v4, g4, i4);
         end
      end
      rdy4 = 1'b1; en4 = 1'b1;
      tick();
      checks++;
      if ({v4, g4, i4} !== {1'b1, 4'b0001, 2'd0}) begin
         errors++;
         $display("FAIL stall_release: got v=%0b g=%b i=%0d want v=1 g=0001 i=0", v4, g4, i4);
      end
   endtask

   task automatic test_mid_reset();
      rr4 = 1'b1; en4 = 1'b1; rdy4 = 1'b1; req4 = 4'b0100;
      tick();
      checks++;
      if ({v4, i4} !== {1'b1, 2'd2}) begin
         errors++;
         $display("FAIL mr_pre: got v=%0b i=%0d want v=1 i=2", v4, i4);
      end
      rdy4 = 1'b0; req4 = 4'b1111;
      tick();
      rst4 = 1'b0;
      tick();
      checks++;
      if ({v4, g4, i4} !== 7'b0) begin
         errors++;
         $display("FAIL mr_reset: got v=%0b g=%b i=%0d want v=0 g=0000 i=0", v4, g4, i4);
      end
      rst4 = 1'b1; rdy4 = 1'b1;
      tick();
      checks++;
      if ({v4, g4, i4} !== {1'b1, 4'b1000, 2'd3}) begin
         errors++;
         $display("FAIL mr_restart: got v=%0b g=%b i=%0d want v=1 g=1000 i=3", v4, g4, i4);
      end
   endtask

   task automatic test_mode_switch();
      logic       rm [5] = '{1, 0, 1, 1, 1};
      logic [7:0] rv [5] = '{8'h20, 8'h31, 8'h31, 8'h31, 8'h00};
      logic       ev [5] = '{1, 1, 1, 1, 0};
      logic [7:0] eg [5] = '{8'h20, 8'h20, 8'h10, 8'h01, 8'h00};
      logic [2:0] ei [5] = '{5, 5, 4, 0, 0};
      en8 = 1'b1; rdy8 = 1'b1;
      for (int n = 0; n < 5; n++) begin
         rr8 = rm[n]; req8 = rv[n];
         tick();
         checks++;
         if ({v8, g8, i8} !== {ev[n], eg[n], ei[n]}) begin
            errors++;
            $display("FAIL mode[%0d] rr=%0b req=%h: got v=%0b g=%b i=%0d want v=%0b g=%b i=%0d",
                     n, rm[n], rv[n], v8, g8, i8, ev[n], eg[n], ei[n]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_enable();
      test_rr();
      test_stall();
      test_mid_reset();
      test_mode_switch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-input priority encoder/arbiter. Successor to the team's 4-to-2 enabled priority encoder.
- Adds a selectable round-robin mode, a one-hot grant and a binary index output, and a valid/ready output handshake with hold-under-stall.
- Sits between request sources (interrupt lines, FIFO non-empty flags) and a consumer that accepts one winner per handshake.

Parameters:
- N, 8, number of request lines (N >= 2).
- IDXW, 3, width of the index output; the integrator must set it to ceil(log2(N)).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  enable; when 0, no new grant is loaded.
- rr_mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- req  input  N  level request vector.
- out_ready  input  1  consumer accepts the current grant.
- out_valid  output  1  grant registers hold a valid winner.
- gnt  output  N  one-hot grant; all zero when out_valid = 0.
- gnt_idx  output  IDXW  binary index of the winner; 0 when out_valid = 0.

Behaviour:
- Reset (rst_n = 0 at a clock edge): out_valid = 0, gnt = 0, gnt_idx = 0, internal pointer ptr = N-1. Reset overrides every other input, including mid-stall.
- Load condition: load = (!out_valid || out_ready) && en && (req != 0). Latency: a req sampled at edge k appears on the outputs after edge k, i.e. one cycle.
- On load: out_valid <= 1, gnt <= onehot(w), gnt_idx <= w, where w is the winner.
- If (!out_valid || out_ready) and load is false: out_valid <= 0, gnt <= 0, gnt_idx <= 0.
- Stall (out_valid && !out_ready): out_valid, gnt and gnt_idx hold exactly. Changes to req, en or rr_mode are ignored until the grant is accepted. A held grant stays valid even if its req bit drops.
- Back-to-back: if out_ready = 1 while out_valid = 1 and load is true, the next winner replaces the current one in the same edge, with no bubble.
- Fixed mode winner: w = highest index i with req[i] = 1. For N = 4 this matches the legacy 4-to-2 encoder (req = 4'b1000 gives 3; 4'b0110 gives 2).
- Round-robin winner: search from ptr downward, wrapping from 0 to N-1 (ptr, ptr-1, ..., 0, N-1, ..., ptr+1). The first set bit wins.
- ptr update: only on a load while rr_mode = 1. ptr <= (w == 0) ? N-1 : w-1, so the winner becomes lowest priority next time. On fixed-mode loads ptr holds.
- Mode switch: takes effect at the next load. ptr is retained across switches, not reset.
- Single requester in round-robin mode: it wins on every load.
- en = 0 with req != 0: no load. A pending grant is still held until accepted, and is not cleared by en.
- req = 0: no load. Once accepted, out_valid drops to 0.
- gnt is always one-hot or zero, and gnt[gnt_idx] = 1 whenever out_valid = 1.

Test Plan:
- Reset and fixed-mode encode (N = 4, rr_mode = 0, out_ready = 1, en = 1): after reset out_valid = 0, gnt = 0. Then req = 8, 4, 2, 1, 0 gives gnt_idx = 3, 2, 1, 0 with out_valid = 1, followed by out_valid = 0. req = 4'b1010 gives gnt_idx = 3.
- Enable gating: en = 0, req = 4'b1000 for 3 cycles gives out_valid = 0 throughout. Raising en gives out_valid = 1, gnt_idx = 3 one cycle later.
- Round-robin fairness (N = 4, rr_mode = 1, req = 4'b1111 constant, out_ready = 1): gnt_idx sequence is 3, 2, 1, 0, 3, 2 with no bubbles. Then req = 4'b0101 starting with ptr = 2 gives 2, 0, 2, 0.
- Stall hold: out_ready = 0 with a grant of gnt_idx = 3 valid, then req changes to 4'b0001 and en = 0 for 4 cycles. gnt = 4'b1000, gnt_idx = 3, out_valid = 1 stay constant. Raising out_ready with en = 1 gives gnt_idx = 0 on the next cycle.
- Mid-stall reset: rst_n = 0 for one edge during a stall gives out_valid = 0, gnt = 0, gnt_idx = 0. Restarting round-robin with req = 4'b1111 gives first winner 3, confirming ptr was reset to N-1.
- Mode switch and N = 8 generics: in round-robin, grant index 5 leaves ptr = 4. Switch to fixed, req = 8'h31 gives gnt_idx = 5, and ptr stays 4. Switch back to round-robin, req = 8'h31 gives gnt_idx = 4.
